// File: rtl/core_mem_arbiter.sv
// Shares one single-port memory between the fetch (I) and load/store (D) ports.
// Round-robin grant, one outstanding transaction, timeout completes with an error flag.
module core_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic        I_ACK,
    output logic [31:0] I_RDATA,
    output logic        I_ERR,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [3:0]  D_BE,
    output logic        D_ACK,
    output logic [31:0] D_RDATA,
    output logic        D_ERR,
    output logic        M_REQ,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_BE,
    input  logic [31:0] M_RDATA,
    input  logic        M_VALID
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic              prio_d_reg, prio_d_next;
    logic              owner_d_reg, owner_d_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              m_req_reg, m_req_next;
    logic              m_we_reg, m_we_next;
    logic [31:0]       m_addr_reg, m_addr_next;
    logic [31:0]       m_wdata_reg, m_wdata_next;
    logic [3:0]        m_be_reg, m_be_next;
    logic              i_ack_reg, i_ack_next;
    logic [31:0]       i_rdata_reg, i_rdata_next;
    logic              i_err_reg, i_err_next;
    logic              d_ack_reg, d_ack_next;
    logic [31:0]       d_rdata_reg, d_rdata_next;
    logic              d_err_reg, d_err_next;

    logic grant_d;
    logic grant_i;
    logic timeout_hit;

    // D wins when it is alone or holds priority; I takes whatever is left.
    assign grant_d     = D_REQ && (!I_REQ || prio_d_reg);
    assign grant_i     = I_REQ && !grant_d;
    assign timeout_hit = (cnt_reg == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            prio_d_reg  <= 1'b1;
            owner_d_reg <= 1'b0;
            cnt_reg     <= '0;
            m_req_reg   <= 1'b0;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
            m_be_reg    <= '0;
            i_ack_reg   <= 1'b0;
            i_rdata_reg <= '0;
            i_err_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            d_rdata_reg <= '0;
            d_err_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            prio_d_reg  <= prio_d_next;
            owner_d_reg <= owner_d_next;
            cnt_reg     <= cnt_next;
            m_req_reg   <= m_req_next;
            m_we_reg    <= m_we_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            m_be_reg    <= m_be_next;
            i_ack_reg   <= i_ack_next;
            i_rdata_reg <= i_rdata_next;
            i_err_reg   <= i_err_next;
            d_ack_reg   <= d_ack_next;
            d_rdata_reg <= d_rdata_next;
            d_err_reg   <= d_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        prio_d_next  = prio_d_reg;
        owner_d_next = owner_d_reg;
        cnt_next     = cnt_reg;
        m_req_next   = 1'b0;
        m_we_next    = m_we_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        m_be_next    = m_be_reg;
        i_ack_next   = 1'b0;
        i_rdata_next = i_rdata_reg;
        i_err_next   = i_err_reg;
        d_ack_next   = 1'b0;
        d_rdata_next = d_rdata_reg;
        d_err_next   = d_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant_d) begin
                    state_next   = ST_WAIT;
                    owner_d_next = 1'b1;
                    prio_d_next  = 1'b0;
                    cnt_next     = '0;
                    m_req_next   = 1'b1;
                    m_we_next    = D_WE;
                    m_addr_next  = D_ADDR;
                    m_wdata_next = D_WDATA;
                    m_be_next    = D_WE ? D_BE : 4'hF;
                end else if (grant_i) begin
                    state_next   = ST_WAIT;
                    owner_d_next = 1'b0;
                    prio_d_next  = 1'b1;
                    cnt_next     = '0;
                    m_req_next   = 1'b1;
                    m_we_next    = 1'b0;
                    m_addr_next  = I_ADDR;
                    m_wdata_next = '0;
                    m_be_next    = 4'hF;
                end
            end

            ST_WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                // A response landing on the last allowed cycle still counts as success.
                if (M_VALID || timeout_hit) begin
                    state_next = ST_RESP;
                    if (owner_d_reg) begin
                        d_ack_next = 1'b1;
                        d_err_next = !M_VALID;
                        if (!m_we_reg) begin
                            d_rdata_next = M_VALID ? M_RDATA : 32'd0;
                        end
                    end else begin
                        i_ack_next   = 1'b1;
                        i_err_next   = !M_VALID;
                        i_rdata_next = M_VALID ? M_RDATA : 32'd0;
                    end
                end
            end

            ST_RESP: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign I_ACK   = i_ack_reg;
    assign I_RDATA = i_rdata_reg;
    assign I_ERR   = i_err_reg;
    assign D_ACK   = d_ack_reg;
    assign D_RDATA = d_rdata_reg;
    assign D_ERR   = d_err_reg;
    assign M_REQ   = m_req_reg;
    assign M_WE    = m_we_reg;
    assign M_ADDR  = m_addr_reg;
    assign M_WDATA = m_wdata_reg;
    assign M_BE    = m_be_reg;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: edge-count transaction model checked every cycle,
// directed scenarios with hand-computed literal expectations.
module tb_core_mem_arbiter;

    localparam int TO = 4;

    logic        CLK;
    logic        RST;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic        I_ACK;
    logic [31:0] I_RDATA;
    logic        I_ERR;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [3:0]  D_BE;
    logic        D_ACK;
    logic [31:0] D_RDATA;
    logic        D_ERR;
    logic        M_REQ;
    logic        M_WE;
    logic [31:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [3:0]  M_BE;
    logic [31:0] M_RDATA;
    logic        M_VALID;

    core_mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA), .I_ERR(I_ERR),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_BE(D_BE),
        .D_ACK(D_ACK), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_BE(M_BE),
        .M_RDATA(M_RDATA), .M_VALID(M_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          mem_on       = 1'b1;
    int          mem_lat      = 1;
    bit          mem_fixed_en = 1'b0;
    logic [31:0] mem_fixed    = 32'd0;
    int          stray_req    = 0;
    int          stray_done   = 0;
    int          mem_cd       = 0;
    logic [31:0] mem_pend     = 32'd0;

    initial begin
        M_VALID = 1'b0;
        M_RDATA = 32'd0;
    end

    always @(negedge CLK) begin
        M_VALID = 1'b0;
        M_RDATA = 32'hBAD0_BAD0;
        if (mem_cd > 0) begin
            mem_cd--;
            if (mem_cd == 0) begin
                M_VALID = 1'b1;
                M_RDATA = mem_pend;
            end
        end
        if (stray_req != stray_done) begin
            stray_done = stray_req;
            M_VALID    = 1'b1;
            M_RDATA    = 32'h0BAD_F00D;
        end
        if (M_REQ === 1'b1 && mem_on) begin
            mem_cd   = mem_lat;
            mem_pend = mem_fixed_en ? mem_fixed : {M_ADDR[15:0], ~M_ADDR[15:0]};
        end
    end

    // ---------------- behavioural model ----------------
    // Works in edge numbers: a grant at edge g sees the memory answer at edges g+1..g+TO,
    // completes with an ACK cycle, and the next grant may be sampled two edges later.
    int unsigned edge_no = 0;
    int unsigned g_edge  = 0;
    int unsigned ok_edge = 0;
    bit          mdl_valid = 1'b0;
    bit          busy = 1'b0;
    bit          prio_d = 1'b1;
    bit          t_d = 1'b0;
    bit          t_we = 1'b0;
    bit          m_cmp = 1'b0;
    bit          wdata_cmp = 1'b0;
    logic        exp_i_ack, exp_d_ack, exp_m_req, exp_i_err, exp_d_err, exp_m_we;
    logic [31:0] exp_i_rdata, exp_d_rdata, exp_m_addr, exp_m_wdata;
    logic [3:0]  exp_m_be;

    always @(posedge CLK) begin
        edge_no++;
        if (RST === 1'b1) begin
            mdl_valid   = 1'b1;
            busy        = 1'b0;
            prio_d      = 1'b1;
            ok_edge     = edge_no + 1;
            m_cmp       = 1'b1;
            wdata_cmp   = 1'b1;
            exp_i_ack   = 1'b0; exp_d_ack = 1'b0; exp_m_req = 1'b0;
            exp_i_err   = 1'b0; exp_d_err = 1'b0; exp_m_we  = 1'b0;
            exp_i_rdata = 32'd0; exp_d_rdata = 32'd0;
            exp_m_addr  = 32'd0; exp_m_wdata = 32'd0; exp_m_be = 4'd0;
        end else if (mdl_valid) begin
            exp_i_ack = 1'b0;
            exp_d_ack = 1'b0;
            exp_m_req = 1'b0;
            if (busy) begin
                if (M_VALID === 1'b1 || (edge_no - g_edge) == TO) begin
                    busy    = 1'b0;
                    ok_edge = edge_no + 2;
                    if (t_d) begin
                        exp_d_ack = 1'b1;
                        exp_d_err = (M_VALID !== 1'b1);
                        if (!t_we) exp_d_rdata = (M_VALID === 1'b1) ? M_RDATA : 32'd0;
                    end else begin
                        exp_i_ack   = 1'b1;
                        exp_i_err   = (M_VALID !== 1'b1);
                        exp_i_rdata = (M_VALID === 1'b1) ? M_RDATA : 32'd0;
                    end
                end
            end else begin
                m_cmp = 1'b0;
                if (edge_no >= ok_edge && (I_REQ === 1'b1 || D_REQ === 1'b1)) begin
                    t_d       = (D_REQ === 1'b1) && (I_REQ !== 1'b1 || prio_d);
                    prio_d    = !t_d;
                    busy      = 1'b1;
                    g_edge    = edge_no;
                    exp_m_req = 1'b1;
                    m_cmp     = 1'b1;
                    if (t_d) begin
                        t_we        = D_WE;
                        exp_m_we    = D_WE;
                        exp_m_addr  = D_ADDR;
                        exp_m_be    = D_WE ? D_BE : 4'hF;
                        exp_m_wdata = D_WDATA;
                        wdata_cmp   = D_WE;
                    end else begin
                        t_we        = 1'b0;
                        exp_m_we    = 1'b0;
                        exp_m_addr  = I_ADDR;
                        exp_m_be    = 4'hF;
                        exp_m_wdata = 32'd0;
                        wdata_cmp   = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (mdl_valid) begin
            chk("i_ack",   I_ACK,   exp_i_ack);
            chk("d_ack",   D_ACK,   exp_d_ack);
            chk("m_req",   M_REQ,   exp_m_req);
            chk("i_rdata", I_RDATA, exp_i_rdata);
            chk("i_err",   I_ERR,   exp_i_err);
            chk("d_rdata", D_RDATA, exp_d_rdata);
            chk("d_err",   D_ERR,   exp_d_err);
            chk("ack_excl", I_ACK & D_ACK, 1'b0);
            if (m_cmp) begin
                chk("m_addr", M_ADDR, exp_m_addr);
                chk("m_we",   M_WE,   exp_m_we);
                chk("m_be",   M_BE,   exp_m_be);
                if (wdata_cmp) chk("m_wdata", M_WDATA, exp_m_wdata);
            end
            if (I_ACK === 1'b1)
                $display("edge %0d: I ack rdata=%h err=%0d", edge_no, I_RDATA, I_ERR);
            if (D_ACK === 1'b1)
                $display("edge %0d: D ack rdata=%h err=%0d", edge_no, D_RDATA, D_ERR);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_ack(input bit is_d, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if ((is_d ? D_ACK : I_ACK) === 1'b1) ok = 1'b1;
        end
        chk(is_d ? "d_ack_wait" : "i_ack_wait", ok, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int nacks;
        bit ord[4];

        RST = 1'b1; I_REQ = 1'b0; I_ADDR = '0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0; D_BE = '0;
        idle(3);
        chk("rst_m_req",   M_REQ,   1'b0);
        chk("rst_m_addr",  M_ADDR,  32'd0);
        chk("rst_d_rdata", D_RDATA, 32'd0);
        chk("rst_i_ack",   I_ACK,   1'b0);
        RST = 1'b0;
        idle(2);

        // 1: load @0x100, L=1
        mem_lat = 1; mem_fixed_en = 1'b1; mem_fixed = 32'hDEADBEEF;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h100;
        idle(1);
        chk("t1_m_req",  M_REQ,  1'b1);
        chk("t1_m_addr", M_ADDR, 32'h100);
        chk("t1_m_be",   M_BE,   4'hF);
        chk("t1_m_we",   M_WE,   1'b0);
        idle(1);
        chk("t1_d_ack_early", D_ACK, 1'b0);
        idle(1);
        chk("t1_d_ack",   D_ACK,   1'b1);
        chk("t1_d_rdata", D_RDATA, 32'hDEADBEEF);
        chk("t1_d_err",   D_ERR,   1'b0);
        D_REQ = 1'b0;
        idle(3);

        // 3: store @0x204
        mem_lat = 2; mem_fixed_en = 1'b0;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h204; D_WDATA = 32'h55555555; D_BE = 4'b0100;
        idle(1);
        chk("t3_m_we",    M_WE,    1'b1);
        chk("t3_m_be",    M_BE,    4'b0100);
        chk("t3_m_wdata", M_WDATA, 32'h55555555);
        chk("t3_m_addr",  M_ADDR,  32'h204);
        wait_ack(1'b1, 10);
        chk("t3_d_rdata_kept", D_RDATA, 32'hDEADBEEF);
        chk("t3_d_err",        D_ERR,   1'b0);
        D_REQ = 1'b0; D_WE = 1'b0; D_BE = 4'd0;
        idle(3);

        // 2: both held from reset, L=2
        RST = 1'b1; I_REQ = 1'b1; I_ADDR = 32'h1000; D_REQ = 1'b1; D_ADDR = 32'h2000;
        idle(1);
        chk("t2_rst_d_rdata", D_RDATA, 32'd0);
        RST = 1'b0;
        nacks = 0;
        for (int c = 0; c < 80 && nacks < 4; c++) begin
            @(negedge CLK);
            if (D_ACK === 1'b1) begin ord[nacks] = 1'b1; nacks++; end
            else if (I_ACK === 1'b1) begin ord[nacks] = 1'b0; nacks++; end
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
        chk("t2_ack_count", nacks, 4);
        chk("t2_grant0_d", ord[0], 1'b1);
        chk("t2_grant1_d", ord[1], 1'b0);
        chk("t2_grant2_d", ord[2], 1'b1);
        chk("t2_grant3_d", ord[3], 1'b0);
        idle(3);

        // 4: fetch timeout, then stray M_VALID
        mem_on = 1'b0;
        I_REQ = 1'b1; I_ADDR = 32'h3000;
        idle(4);
        chk("t4_i_ack_early", I_ACK, 1'b0);
        idle(1);
        chk("t4_i_ack",   I_ACK,   1'b1);
        chk("t4_i_err",   I_ERR,   1'b1);
        chk("t4_i_rdata", I_RDATA, 32'd0);
        I_REQ = 1'b0;
        idle(1);
        stray_req++;
        idle(3);
        chk("t4_stray_i_err", I_ERR, 1'b1);
        chk("t4_stray_i_ack", I_ACK, 1'b0);

        // 6: M_VALID on the last WAIT cycle wins, one cycle later times out
        mem_on = 1'b1; mem_lat = 3; mem_fixed_en = 1'b1; mem_fixed = 32'h13579BDF;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h400;
        idle(5);
        chk("t6_d_ack",   D_ACK,   1'b1);
        chk("t6_d_err",   D_ERR,   1'b0);
        chk("t6_d_rdata", D_RDATA, 32'h13579BDF);
        D_REQ = 1'b0;
        idle(3);
        mem_lat = 4;
        D_REQ = 1'b1; D_ADDR = 32'h600;
        idle(5);
        chk("t6b_d_ack",   D_ACK,   1'b1);
        chk("t6b_d_err",   D_ERR,   1'b1);
        chk("t6b_d_rdata", D_RDATA, 32'd0);
        D_REQ = 1'b0;
        idle(3);

        // 5: reset during WAIT of a load
        mem_on = 1'b0;
        D_REQ = 1'b1; D_ADDR = 32'h700;
        idle(1);
        chk("t5_m_req", M_REQ, 1'b1);
        idle(1);
        RST = 1'b1; D_REQ = 1'b0;
        idle(1);
        chk("t5_m_addr", M_ADDR, 32'd0);
        chk("t5_d_err",  D_ERR,  1'b0);
        chk("t5_d_ack",  D_ACK,  1'b0);
        RST = 1'b0;
        idle(3);
        stray_req++;
        idle(3);
        mem_on = 1'b1; mem_lat = 1; mem_fixed_en = 1'b0;
        I_REQ = 1'b1; I_ADDR = 32'h800;
        idle(3);
        chk("t5_i_ack",   I_ACK,   1'b1);
        chk("t5_i_rdata", I_RDATA, 32'h0800F7FF);
        chk("t5_i_err",   I_ERR,   1'b0);
        I_REQ = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
